// File: rtl/mesh_match_resp_ni_pkg.sv
// Shared field widths and mesh payload pack/unpack offsets for the match-PE network interfaces.
// The job-PE-side NI uses the same offset macros so both ends agree on the packet layout.
`ifndef MESH_W
`define MESH_W 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 5
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 6
`endif

// Request payload, LSB first: job_pe_idx, tag, history_addr, head_addr
`ifndef MNI_REQ_PE_LSB
`define MNI_REQ_PE_LSB   0
`define MNI_REQ_TAG_LSB  (`MNI_REQ_PE_LSB + `NUM_JOB_PE_LOG2)
`define MNI_REQ_HIST_LSB (`MNI_REQ_TAG_LSB + `LAZY_LEN_LOG2)
`define MNI_REQ_HEAD_LSB (`MNI_REQ_HIST_LSB + `ADDR_WIDTH)
`define MNI_REQ_BITS     (`MNI_REQ_HEAD_LSB + `ADDR_WIDTH)
`define MNI_RESP_TAG_LSB 0
`define MNI_RESP_LEN_LSB (`MNI_RESP_TAG_LSB + `LAZY_LEN_LOG2)
`define MNI_RESP_BITS    (`MNI_RESP_LEN_LSB + `MATCH_LEN_WIDTH)
`endif

package mesh_match_resp_ni_pkg;

  localparam int unsigned MESH_W_DEF = `MESH_W;
  localparam int unsigned ADDR_W     = `ADDR_WIDTH;
  localparam int unsigned TAG_W      = `LAZY_LEN_LOG2;
  localparam int unsigned PE_W       = `NUM_JOB_PE_LOG2;
  localparam int unsigned LEN_W      = `MATCH_LEN_WIDTH;

  localparam int unsigned REQ_PE_LSB   = `MNI_REQ_PE_LSB;
  localparam int unsigned REQ_TAG_LSB  = `MNI_REQ_TAG_LSB;
  localparam int unsigned REQ_HIST_LSB = `MNI_REQ_HIST_LSB;
  localparam int unsigned REQ_HEAD_LSB = `MNI_REQ_HEAD_LSB;
  localparam int unsigned REQ_BITS     = `MNI_REQ_BITS;
  localparam int unsigned RESP_TAG_LSB = `MNI_RESP_TAG_LSB;
  localparam int unsigned RESP_LEN_LSB = `MNI_RESP_LEN_LSB;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PE_W-1:0]  pe;
  } ret_entry_t;

endpackage

// File: rtl/mesh_ni_ret_fifo.sv
// Return-address FIFO: power-of-two depth, wrap-around pointers plus an occupancy count.
module mesh_ni_ret_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mesh_match_resp_ni.sv
// Mesh NI in front of a shared match PE: ejects match requests, remembers who asked,
// and injects each match result back to the originating job PE as a response packet.
module mesh_match_resp_ni
  import mesh_match_resp_ni_pkg::*;
#(
  parameter int unsigned W           = MESH_W_DEF,
  parameter int unsigned X_SIZE      = 8,
  parameter int unsigned Y_SIZE      = 8,
  parameter int unsigned OUTSTANDING = 4,
  localparam int unsigned XW = $clog2(X_SIZE),
  localparam int unsigned YW = $clog2(Y_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XW-1:0]     i_coord_x,
  input  logic [YW-1:0]     i_coord_y,
  input  logic              i_mesh_valid,
  input  logic [XW-1:0]     i_mesh_dst_x,
  input  logic [YW-1:0]     i_mesh_dst_y,
  input  logic [W-1:0]      i_mesh_payload,
  output logic              i_mesh_ready,
  output logic              o_mesh_valid,
  output logic [XW-1:0]     o_mesh_dst_x,
  output logic [YW-1:0]     o_mesh_dst_y,
  output logic [W-1:0]      o_mesh_payload,
  input  logic              o_mesh_ready,
  output logic              o_req_valid,
  output logic [ADDR_W-1:0] o_req_head_addr,
  output logic [ADDR_W-1:0] o_req_history_addr,
  input  logic              i_req_ready,
  input  logic              i_resp_valid,
  input  logic [LEN_W-1:0]  i_resp_match_len,
  output logic              o_resp_ready,
  output logic              o_err_misroute
);

  logic       req_fire;
  logic       mesh_fire;
  logic       is_local;
  logic       ret_push;
  logic       ret_full;
  logic       ret_empty;
  logic       resp_fire;
  logic       out_fire;
  ret_entry_t ret_wr;
  ret_entry_t ret_rd;
  logic [W-1:0] resp_payload;
  logic       unused_payload_bits;

  assign unused_payload_bits = ^i_mesh_payload[W-1:REQ_BITS];

  // Request side
  assign req_fire     = o_req_valid & i_req_ready;
  assign i_mesh_ready = (~o_req_valid | req_fire) & ~ret_full;
  assign mesh_fire    = i_mesh_valid & i_mesh_ready;
  assign is_local     = (i_mesh_dst_x == i_coord_x) && (i_mesh_dst_y == i_coord_y)
                        && i_mesh_dst_y[0];
  assign ret_push     = mesh_fire & is_local;
  assign ret_wr.tag   = i_mesh_payload[REQ_TAG_LSB +: TAG_W];
  assign ret_wr.pe    = i_mesh_payload[REQ_PE_LSB +: PE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req_valid        <= 1'b0;
      o_req_head_addr    <= '0;
      o_req_history_addr <= '0;
      o_err_misroute     <= 1'b0;
    end else begin
      if (ret_push) begin
        o_req_valid        <= 1'b1;
        o_req_head_addr    <= i_mesh_payload[REQ_HEAD_LSB +: ADDR_W];
        o_req_history_addr <= i_mesh_payload[REQ_HIST_LSB +: ADDR_W];
      end else if (req_fire) begin
        o_req_valid <= 1'b0;
      end
      if (mesh_fire && !is_local) o_err_misroute <= 1'b1;
    end
  end

  mesh_ni_ret_fifo #(
    .WIDTH($bits(ret_entry_t)),
    .DEPTH(OUTSTANDING)
  ) u_ret_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (ret_push),
    .wr_data(ret_wr),
    .pop    (resp_fire),
    .rd_data(ret_rd),
    .full   (ret_full),
    .empty  (ret_empty)
  );

  // Response side: results are only taken while a return address is waiting
  assign out_fire     = o_mesh_valid & o_mesh_ready;
  assign o_resp_ready = (~o_mesh_valid | o_mesh_ready) & ~ret_empty;
  assign resp_fire    = i_resp_valid & o_resp_ready;

  always_comb begin
    resp_payload = '0;
    resp_payload[RESP_TAG_LSB +: TAG_W] = ret_rd.tag;
    resp_payload[RESP_LEN_LSB +: LEN_W] = i_resp_match_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mesh_valid   <= 1'b0;
      o_mesh_dst_x   <= '0;
      o_mesh_dst_y   <= '0;
      o_mesh_payload <= '0;
    end else begin
      if (resp_fire) begin
        o_mesh_valid   <= 1'b1;
        o_mesh_dst_x   <= ret_rd.pe[XW-1:0];
        o_mesh_dst_y   <= YW'({ret_rd.pe[PE_W-1:XW], 1'b0});
        o_mesh_payload <= resp_payload;
      end else if (out_fire) begin
        o_mesh_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesh_match_resp_ni.sv
// Bench for mesh_match_resp_ni at node (1,3): vector table plus scoreboarded match-PE model.
module tb_mesh_match_resp_ni;
  import mesh_match_resp_ni_pkg::*;

  localparam int W  = 64;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int BIG = 1000000;

  logic              clk;
  logic              rst_n;
  logic [XW-1:0]     i_coord_x;
  logic [YW-1:0]     i_coord_y;
  logic              i_mesh_valid;
  logic [XW-1:0]     i_mesh_dst_x;
  logic [YW-1:0]     i_mesh_dst_y;
  logic [W-1:0]      i_mesh_payload;
  logic              i_mesh_ready;
  logic              o_mesh_valid;
  logic [XW-1:0]     o_mesh_dst_x;
  logic [YW-1:0]     o_mesh_dst_y;
  logic [W-1:0]      o_mesh_payload;
  logic              o_mesh_ready;
  logic              o_req_valid;
  logic [15:0]       o_req_head_addr;
  logic [15:0]       o_req_history_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [5:0]        i_resp_match_len;
  logic              o_resp_ready;
  logic              o_err_misroute;

  mesh_match_resp_ni #(
    .W(64), .X_SIZE(8), .Y_SIZE(8), .OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_coord_x(i_coord_x), .i_coord_y(i_coord_y),
    .i_mesh_valid(i_mesh_valid), .i_mesh_dst_x(i_mesh_dst_x), .i_mesh_dst_y(i_mesh_dst_y),
    .i_mesh_payload(i_mesh_payload), .i_mesh_ready(i_mesh_ready),
    .o_mesh_valid(o_mesh_valid), .o_mesh_dst_x(o_mesh_dst_x), .o_mesh_dst_y(o_mesh_dst_y),
    .o_mesh_payload(o_mesh_payload), .o_mesh_ready(o_mesh_ready),
    .o_req_valid(o_req_valid), .o_req_head_addr(o_req_head_addr),
    .o_req_history_addr(o_req_history_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_match_len(i_resp_match_len),
    .o_resp_ready(o_resp_ready), .o_err_misroute(o_err_misroute)
  );

  typedef struct {
    logic [2:0]  dx, dy;
    logic [4:0]  pe;
    logic [1:0]  tag;
    logic [15:0] head, hist;
    logic [5:0]  len;
    logic [24:0] junk;
    logic        exp_ok;
    logic [2:0]  exp_x, exp_y;
    logic        exp_err;
  } vec_t;

  typedef struct packed { logic [2:0] x; logic [2:0] y; logic [63:0] pl; } rsp_t;
  typedef struct packed { logic [15:0] head; logic [15:0] hist; } rq_t;

  vec_t        tbl [8];
  rsp_t        resp_exp_q [$];
  rq_t         req_exp_q [$];
  logic [5:0]  pe_len_q [$];
  logic [5:0]  pe_q [$];
  logic [1:0]  rx_tags [$];
  int          rx_count;
  int          pe_credits;
  logic        man_resp;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] dx, input logic [2:0] dy, input logic [4:0] pe,
                               input logic [1:0] tag, input logic [15:0] head, input logic [15:0] hist,
                               input logic [5:0] len, input logic [24:0] junk, input logic ok,
                               input logic [2:0] ex, input logic [2:0] ey, input logic err);
    vec_t v;
    v.dx = dx; v.dy = dy; v.pe = pe; v.tag = tag; v.head = head; v.hist = hist;
    v.len = len; v.junk = junk; v.exp_ok = ok; v.exp_x = ex; v.exp_y = ey; v.exp_err = err;
    return v;
  endfunction

  function automatic void push_expect(input vec_t v);
    rq_t  r;
    rsp_t s;
    if (v.exp_ok) begin
      r.head = v.head; r.hist = v.hist;
      req_exp_q.push_back(r);
      pe_len_q.push_back(v.len);
      s.x = v.exp_x; s.y = v.exp_y; s.pl = {58'd0, v.len, v.tag};
      resp_exp_q.push_back(s);
    end
  endfunction

  task automatic drive_pkt(input vec_t v);
    i_mesh_valid   = 1'b1;
    i_mesh_dst_x   = v.dx;
    i_mesh_dst_y   = v.dy;
    i_mesh_payload = {v.junk, v.head, v.hist, v.tag, v.pe};
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input vec_t v, input string name);
    bit acc = 1'b0;
    drive_pkt(v);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (i_mesh_ready) begin acc = 1'b1; break; end
    end
    if (acc) push_expect(v);
    @(posedge clk); #1;
    i_mesh_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s_accept: got no handshake, expected i_mesh_ready within 50 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (resp_exp_q.size() == 0 && req_exp_q.size() == 0) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d responses still pending, expected 0", name, resp_exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_i_mesh_ready"}, i_mesh_ready, 1);
    chk({name, "_o_mesh_valid"}, o_mesh_valid, 0);
    chk({name, "_o_req_valid"}, o_req_valid, 0);
    chk({name, "_o_resp_ready"}, o_resp_ready, 0);
    chk({name, "_o_err_misroute"}, o_err_misroute, 0);
    chk({name, "_o_mesh_dst_x"}, o_mesh_dst_x, 0);
    chk({name, "_o_mesh_dst_y"}, o_mesh_dst_y, 0);
    chk({name, "_o_mesh_payload"}, o_mesh_payload, 0);
    chk({name, "_o_req_head"}, o_req_head_addr, 0);
    chk({name, "_o_req_hist"}, o_req_history_addr, 0);
  endtask

  // Match-PE model and output scoreboard. Handshakes are observed at the negedge
  // (inputs are stable there); a result offered in the same cycle as its request.
  initial begin
    rq_t  r;
    rsp_t s;
    i_resp_valid     = 1'b0;
    i_resp_match_len = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_req_valid && i_req_ready) begin
          if (req_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_req: got request head=0x%0h, expected none", o_req_head_addr);
          end else begin
            r = req_exp_q.pop_front();
            chk("req_head", o_req_head_addr, r.head);
            chk("req_hist", o_req_history_addr, r.hist);
          end
          if (pe_len_q.size() > 0) pe_q.push_back(pe_len_q.pop_front());
        end
        if (o_mesh_valid && o_mesh_ready) begin
          rx_count++;
          rx_tags.push_back(o_mesh_payload[1:0]);
          if (resp_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_resp: got payload 0x%0h, expected none", o_mesh_payload);
          end else begin
            s = resp_exp_q.pop_front();
            chk("resp_dst_x", o_mesh_dst_x, s.x);
            chk("resp_dst_y", o_mesh_dst_y, s.y);
            chk("resp_payload", o_mesh_payload, s.pl);
          end
        end
      end
      i_resp_valid     = man_resp || (pe_q.size() > 0 && pe_credits > 0);
      i_resp_match_len = (pe_q.size() > 0) ? pe_q[0] : '0;
      #1;
      if (rst_n && i_resp_valid && o_resp_ready && pe_q.size() > 0) begin
        void'(pe_q.pop_front());
        if (pe_credits > 0) pe_credits--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    errors = 0; checks = 0; rx_count = 0;
    pe_credits = BIG; man_resp = 1'b0;
    rst_n = 1'b0;
    i_coord_x = 3'd1; i_coord_y = 3'd3;
    i_mesh_valid = 1'b0; i_mesh_dst_x = '0; i_mesh_dst_y = '0; i_mesh_payload = '0;
    o_mesh_ready = 1'b1; i_req_ready = 1'b1;

    //          dx dy   pe     tag head      hist      len    junk           ok ex ey err
    tbl[0] = mkv(1, 3, 5'd10, 2, 16'h0100, 16'h0040, 6'd7,  25'd0,         1, 2, 2, 0);
    tbl[1] = mkv(1, 3, 5'd31, 3, 16'hFFFF, 16'hFFFF, 6'd63, 25'h1ABCDEF,   1, 7, 6, 0);
    tbl[2] = mkv(1, 3, 5'd0,  0, 16'h0000, 16'h1234, 6'd0,  25'd0,         1, 0, 0, 0);
    tbl[3] = mkv(1, 2, 5'd9,  1, 16'h2222, 16'h3333, 6'd5,  25'd0,         0, 0, 0, 1);
    tbl[4] = mkv(2, 3, 5'd9,  1, 16'h4444, 16'h5555, 6'd5,  25'd0,         0, 0, 0, 1);
    tbl[5] = mkv(1, 3, 5'd21, 1, 16'hABCD, 16'h5555, 6'd33, 25'h0F0F0F,    1, 5, 4, 1);
    tbl[6] = mkv(5, 5, 5'd3,  2, 16'h6666, 16'h7777, 6'd9,  25'd0,         0, 0, 0, 1);
    tbl[7] = mkv(1, 3, 5'd7,  1, 16'h0F0F, 16'hF0F0, 6'd1,  25'd0,         1, 7, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single round trip: response two cycles after the mesh handshake
    send(tbl[0], "rt");
    chk("rt_req_valid_t1", o_req_valid, 1);
    chk("rt_out_idle_t1", o_mesh_valid, 0);
    @(posedge clk); #1;
    chk("rt_out_valid_t2", o_mesh_valid, 1);
    chk("rt_out_x", o_mesh_dst_x, 2);
    chk("rt_out_y", o_mesh_dst_y, 2);
    chk("rt_out_payload", o_mesh_payload, 64'd30);
    wait_drain("rt");

    for (int i = 0; i < 8; i++) begin
      send(tbl[i], $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_err_flag", i), o_err_misroute, tbl[i].exp_err);
      if (!tbl[i].exp_ok) chk($sformatf("tbl%0d_no_req", i), o_req_valid, 0);
    end
    wait_drain("tbl");

    // FIFO full: four outstanding, fifth deferred until one cycle after a pop
    pe_credits = 0;
    send(tbl[0], "full0");
    send(tbl[1], "full1");
    send(tbl[2], "full2");
    send(tbl[5], "full3");
    chk("full_ready_low", i_mesh_ready, 0);
    drive_pkt(tbl[7]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      chk($sformatf("full_hold%0d", c), i_mesh_ready, 0);
    end
    @(posedge clk); #1;
    pe_credits = 1;
    @(negedge clk); #2;
    chk("full_pop_now", i_resp_valid & o_resp_ready, 1);
    chk("full_ready_during_pop", i_mesh_ready, 0);
    @(negedge clk); #2;
    chk("full_ready_after_pop", i_mesh_ready, 1);
    push_expect(tbl[7]);
    @(posedge clk); #1;
    i_mesh_valid = 1'b0;
    chk("full_fifth_loaded", o_req_valid, 1);
    chk("full_fifth_head", o_req_head_addr, 16'h0F0F);
    pe_credits = BIG;
    wait_drain("full");

    // Result with nothing outstanding must stall
    man_resp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      chk($sformatf("orphan_ready%0d", c), o_resp_ready, 0);
      chk($sformatf("orphan_no_out%0d", c), o_mesh_valid, 0);
    end
    @(posedge clk); #1;
    man_resp = 1'b0;

    // Output backpressure: held stable, then drained in request order
    rx_tags.delete();
    o_mesh_ready = 1'b0;
    send(tbl[2], "bp0");
    send(tbl[5], "bp1");
    send(tbl[0], "bp2");
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (o_mesh_valid) begin seen = 1'b1; break; end
      end
      chk("bp_out_valid_seen", seen, 1);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      chk($sformatf("bp_valid%0d", c), o_mesh_valid, 1);
      if (resp_exp_q.size() > 0) begin
        chk($sformatf("bp_x%0d", c), o_mesh_dst_x, resp_exp_q[0].x);
        chk($sformatf("bp_y%0d", c), o_mesh_dst_y, resp_exp_q[0].y);
        chk($sformatf("bp_pl%0d", c), o_mesh_payload, resp_exp_q[0].pl);
      end
    end
    @(posedge clk); #1;
    o_mesh_ready = 1'b1;
    wait_drain("bp");
    chk("bp_rx_count", rx_tags.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rx_tags.size()) chk($sformatf("bp_order%0d", i), rx_tags[i], i);

    // Reset with three return entries outstanding
    pe_credits = 0;
    send(tbl[2], "rst0");
    send(tbl[5], "rst1");
    send(tbl[0], "rst2");
    @(posedge clk); #1;
    chk("rst_pending_ready", o_resp_ready, 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    resp_exp_q.delete(); req_exp_q.delete(); pe_len_q.delete(); pe_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pe_credits = BIG;
    @(posedge clk); #1;
    n0 = rx_count;
    send(tbl[1], "post");
    wait_drain("post");
    chk("post_rx_count", rx_count - n0, 1);
    chk("post_err_clear", o_err_misroute, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
